// File: rtl/mem2axi_master_pkg.sv
// AXI4 channel and bundle types for the system crossbar port used by mem2axi_master.
// The MEM2AXI_MASTER_ERR_EN build option is consumed by mem2axi_master, not here.
package mem2axi_master_pkg;

    localparam int unsigned AxiAddrWidth     = 32;
    localparam int unsigned AxiDataWidth     = 512;
    localparam int unsigned AxiStrbWidth     = AxiDataWidth / 8;
    localparam int unsigned AxiSystemIdWidth = 6;
    localparam int unsigned AxiUserWidth     = 1;

    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    typedef struct packed {
        logic [AxiSystemIdWidth-1:0] id;
        logic [AxiAddrWidth-1:0]     addr;
        logic [7:0]                  len;
        logic [2:0]                  size;
        logic [1:0]                  burst;
        logic                        lock;
        logic [3:0]                  cache;
        logic [2:0]                  prot;
        logic [3:0]                  qos;
        logic [3:0]                  region;
        logic [5:0]                  atop;
        logic [AxiUserWidth-1:0]     user;
    } axi_system_aw_chan_t;

    typedef struct packed {
        logic [AxiSystemIdWidth-1:0] id;
        logic [AxiAddrWidth-1:0]     addr;
        logic [7:0]                  len;
        logic [2:0]                  size;
        logic [1:0]                  burst;
        logic                        lock;
        logic [3:0]                  cache;
        logic [2:0]                  prot;
        logic [3:0]                  qos;
        logic [3:0]                  region;
        logic [AxiUserWidth-1:0]     user;
    } axi_system_ar_chan_t;

    typedef struct packed {
        logic [AxiDataWidth-1:0] data;
        logic [AxiStrbWidth-1:0] strb;
        logic                    last;
        logic [AxiUserWidth-1:0] user;
    } axi_system_w_chan_t;

    typedef struct packed {
        logic [AxiSystemIdWidth-1:0] id;
        logic [1:0]                  resp;
        logic [AxiUserWidth-1:0]     user;
    } axi_system_b_chan_t;

    typedef struct packed {
        logic [AxiSystemIdWidth-1:0] id;
        logic [AxiDataWidth-1:0]     data;
        logic [1:0]                  resp;
        logic                        last;
        logic [AxiUserWidth-1:0]     user;
    } axi_system_r_chan_t;

    typedef struct packed {
        axi_system_aw_chan_t aw;
        logic                aw_valid;
        axi_system_w_chan_t  w;
        logic                w_valid;
        logic                b_ready;
        axi_system_ar_chan_t ar;
        logic                ar_valid;
        logic                r_ready;
    } axi_system_req_t;

    typedef struct packed {
        logic               aw_ready;
        logic               ar_ready;
        logic               w_ready;
        logic               b_valid;
        axi_system_b_chan_t b;
        logic               r_valid;
        axi_system_r_chan_t r;
    } axi_system_resp_t;

    // SLVERR and DECERR both have the upper response bit set.
    function automatic logic resp_is_err(logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/mem2axi_order_fifo.sv
// Direction-order FIFO (1 = write) for mem2axi_master; synchronous active-high reset.
module mem2axi_order_fifo #(
    parameter int unsigned Depth = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic wdata,
    input  logic pop,
    output logic rdata,
    output logic full,
    output logic empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Depth-1:0] mem_q;
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;

    function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);

endmodule

// File: rtl/mem2axi_master.sv
// TCDM-style req/gnt/rvalid to single-beat AXI4 master, responses returned in request order.
// Build option MEM2AXI_MASTER_ERR_EN: flag SLVERR/DECERR responses on mem_err_o.
module mem2axi_master
    import mem2axi_master_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 512,
    parameter int unsigned IdWidth   = 6,
    parameter int unsigned MaxTxns   = 4,
    parameter type axi_req_t  = axi_system_req_t,
    parameter type axi_resp_t = axi_system_resp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   mem_req_i,
    output logic                   mem_gnt_o,
    input  logic [AddrWidth-1:0]   mem_addr_i,
    input  logic                   mem_we_i,
    input  logic [DataWidth-1:0]   mem_wdata_i,
    input  logic [DataWidth/8-1:0] mem_strb_i,
    output logic                   mem_rvalid_o,
    output logic [DataWidth-1:0]   mem_rdata_o,
    output logic                   mem_err_o,
    output axi_req_t               axi_req_o,
    input  axi_resp_t              axi_resp_i,
    output logic                   busy_o
);

    localparam logic [2:0] AxiSize = 3'($clog2(DataWidth / 8));

    logic aw_sent_q, aw_sent_d, w_sent_q, w_sent_d;
    logic fifo_full, fifo_empty, fifo_head;
    logic issue_ok, ar_valid, aw_valid, w_valid;
    logic ar_hs, aw_hs, w_hs, wr_gnt, gnt;
    logic r_ready, b_ready, r_hs, b_hs;
    logic [IdWidth-1:0] axi_id;
    logic unused_resp;

    assign axi_id = '0;

    // Outputs are forced idle while reset is held so nothing handshakes during reset.
    assign issue_ok = mem_req_i & ~fifo_full & ~rst_i;
    assign ar_valid = issue_ok & ~mem_we_i;
    assign aw_valid = issue_ok & mem_we_i & ~aw_sent_q;
    assign w_valid  = issue_ok & mem_we_i & ~w_sent_q;

    assign ar_hs  = ar_valid & axi_resp_i.ar_ready;
    assign aw_hs  = aw_valid & axi_resp_i.aw_ready;
    assign w_hs   = w_valid & axi_resp_i.w_ready;
    // Both flags set at once cannot occur: the second handshake grants and clears them.
    assign wr_gnt = issue_ok & mem_we_i & (aw_sent_q | aw_hs) & (w_sent_q | w_hs);
    assign gnt    = ar_hs | wr_gnt;

    assign r_ready = ~fifo_empty & ~fifo_head & ~rst_i;
    assign b_ready = ~fifo_empty & fifo_head & ~rst_i;
    assign r_hs    = r_ready & axi_resp_i.r_valid;
    assign b_hs    = b_ready & axi_resp_i.b_valid;

    always_comb begin
        aw_sent_d = aw_sent_q;
        w_sent_d  = w_sent_q;
        if (wr_gnt) begin
            aw_sent_d = 1'b0;
            w_sent_d  = 1'b0;
        end else begin
            if (aw_hs) aw_sent_d = 1'b1;
            if (w_hs)  w_sent_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_sent_q <= 1'b0;
            w_sent_q  <= 1'b0;
        end else begin
            aw_sent_q <= aw_sent_d;
            w_sent_q  <= w_sent_d;
        end
    end

    mem2axi_order_fifo #(
        .Depth (MaxTxns)
    ) i_order_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (gnt),
        .wdata (mem_we_i),
        .pop   (r_hs | b_hs),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        axi_req_o           = '0;
        axi_req_o.aw.id     = axi_id;
        axi_req_o.aw.addr   = mem_addr_i;
        axi_req_o.aw.size   = AxiSize;
        axi_req_o.aw.burst  = BurstIncr;
        axi_req_o.aw_valid  = aw_valid;
        axi_req_o.w.data    = mem_wdata_i;
        axi_req_o.w.strb    = mem_strb_i;
        axi_req_o.w.last    = 1'b1;
        axi_req_o.w_valid   = w_valid;
        axi_req_o.ar.id     = axi_id;
        axi_req_o.ar.addr   = mem_addr_i;
        axi_req_o.ar.size   = AxiSize;
        axi_req_o.ar.burst  = BurstIncr;
        axi_req_o.ar_valid  = ar_valid;
        axi_req_o.r_ready   = r_ready;
        axi_req_o.b_ready   = b_ready;
    end

    assign mem_gnt_o    = gnt;
    assign mem_rvalid_o = r_hs | b_hs;
    assign mem_rdata_o  = r_hs ? axi_resp_i.r.data : '0;
    assign busy_o       = ~fifo_empty | aw_sent_q | w_sent_q;

`ifdef MEM2AXI_MASTER_ERR_EN
    assign mem_err_o = (r_hs & resp_is_err(axi_resp_i.r.resp))
                     | (b_hs & resp_is_err(axi_resp_i.b.resp));
`else
    assign mem_err_o = 1'b0;
`endif

    assign unused_resp = ^axi_resp_i;

endmodule

// File: tb/tb_mem2axi_master.sv
// Directed self-checking bench for mem2axi_master (default or MEM2AXI_MASTER_ERR_EN build).
module tb_mem2axi_master;
    import mem2axi_master_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic mem_req, mem_gnt, mem_we, mem_rvalid, mem_err, busy;
    logic [31:0]  mem_addr;
    logic [511:0] mem_wdata, mem_rdata;
    logic [63:0]  mem_strb;
    axi_system_req_t  axi_req;
    axi_system_resp_t axi_resp;

    int n_checks = 0;
    int n_fail   = 0;

    logic [511:0] data_a = {16{32'hDEADBEEF}};
    logic [511:0] data_b = {8{64'h0123_4567_89AB_CDEF}};

    always #5 clk = ~clk;

    mem2axi_master dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .mem_req_i    (mem_req),
        .mem_gnt_o    (mem_gnt),
        .mem_addr_i   (mem_addr),
        .mem_we_i     (mem_we),
        .mem_wdata_i  (mem_wdata),
        .mem_strb_i   (mem_strb),
        .mem_rvalid_o (mem_rvalid),
        .mem_rdata_o  (mem_rdata),
        .mem_err_o    (mem_err),
        .axi_req_o    (axi_req),
        .axi_resp_i   (axi_resp),
        .busy_o       (busy)
    );

    // Advance to just after the next rising edge; inputs are driven here, checks follow #1 later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_strb = '0;
        axi_resp = '0;
        step(); step();
        rst = 1'b0;
        settle();
        n_checks++;
        if ({axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid, axi_req.r_ready,
             axi_req.b_ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_valids: got %b want 00000", {axi_req.ar_valid,
                     axi_req.aw_valid, axi_req.w_valid, axi_req.r_ready, axi_req.b_ready});
        end
        n_checks++;
        if ({mem_gnt, mem_rvalid, mem_err, busy} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_mem: got %b want 0000", {mem_gnt, mem_rvalid, mem_err, busy});
        end
    endtask

    task automatic test_read();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h8000_0040;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_checks++;
            if (axi_req.ar_valid !== 1'b1 || mem_gnt !== 1'b0) begin
                n_fail++;
                $display("FAIL read_wait: ar_valid=%b gnt=%b want 1 0", axi_req.ar_valid, mem_gnt);
            end
            step();
        end
        axi_resp.ar_ready = 1'b1;
        settle();
        n_checks++;
        if (mem_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL read_gnt: got %b want 1", mem_gnt);
        end
        n_checks++;
        if (axi_req.ar.addr !== 32'h8000_0040 || axi_req.ar.size !== 3'd6 ||
            axi_req.ar.len !== 8'd0 || axi_req.ar.burst !== 2'b01 || axi_req.ar.id !== 6'd0) begin
            n_fail++;
            $display("FAIL read_ar_fields: addr=%h size=%0d len=%0d burst=%0d id=%0d want 80000040 6 0 1 0",
                     axi_req.ar.addr, axi_req.ar.size, axi_req.ar.len, axi_req.ar.burst,
                     axi_req.ar.id);
        end
        step();
        mem_req = 1'b0; axi_resp.ar_ready = 1'b0;
        axi_resp.r_valid = 1'b1; axi_resp.r.data = data_a; axi_resp.r.resp = RespOkay;
        settle();
        n_checks++;
        if (mem_rvalid !== 1'b1 || mem_rdata !== data_a || axi_req.r_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL read_resp: rvalid=%b r_ready=%b rdata=%h want 1 1 %h", mem_rvalid,
                     axi_req.r_ready, mem_rdata[63:0], data_a[63:0]);
        end
        step();
        axi_resp.r_valid = 1'b0;
        settle();
        n_checks++;
        if (busy !== 1'b0 || mem_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_idle: busy=%b rvalid=%b want 0 0", busy, mem_rvalid);
        end
    endtask

    task automatic test_write();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8000_0000; mem_strb = 64'h000F;
        mem_wdata = data_b;
        axi_resp.w_ready = 1'b1;
        settle();
        n_checks++;
        if (axi_req.aw_valid !== 1'b1 || axi_req.w_valid !== 1'b1 || mem_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL write_first: aw_valid=%b w_valid=%b gnt=%b want 1 1 0",
                     axi_req.aw_valid, axi_req.w_valid, mem_gnt);
        end
        n_checks++;
        if (axi_req.w.strb !== 64'h000F || axi_req.w.last !== 1'b1 || axi_req.w.data !== data_b)
        begin
            n_fail++;
            $display("FAIL write_w_fields: strb=%h last=%b want 000f 1", axi_req.w.strb,
                     axi_req.w.last);
        end
        step();
        axi_resp.w_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_checks++;
            if (axi_req.w_valid !== 1'b0 || axi_req.aw_valid !== 1'b1 || mem_gnt !== 1'b0 ||
                busy !== 1'b1) begin
                n_fail++;
                $display("FAIL write_w_sent: w_valid=%b aw_valid=%b gnt=%b busy=%b want 0 1 0 1",
                         axi_req.w_valid, axi_req.aw_valid, mem_gnt, busy);
            end
            step();
        end
        axi_resp.aw_ready = 1'b1;
        settle();
        n_checks++;
        if (mem_gnt !== 1'b1 || axi_req.aw.addr !== 32'h8000_0000 || axi_req.aw.size !== 3'd6)
        begin
            n_fail++;
            $display("FAIL write_gnt: gnt=%b addr=%h size=%0d want 1 80000000 6", mem_gnt,
                     axi_req.aw.addr, axi_req.aw.size);
        end
        step();
        mem_req = 1'b0; axi_resp.aw_ready = 1'b0;
        axi_resp.b_valid = 1'b1; axi_resp.b.resp = RespOkay;
        settle();
        n_checks++;
        if (mem_rvalid !== 1'b1 || axi_req.b_ready !== 1'b1 || mem_rdata !== '0 ||
            mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL write_b: rvalid=%b b_ready=%b err=%b want 1 1 0", mem_rvalid,
                     axi_req.b_ready, mem_err);
        end
        step();
        axi_resp.b_valid = 1'b0;
        settle();
        n_checks++;
        if (mem_rvalid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL write_single: rvalid=%b busy=%b want 0 0", mem_rvalid, busy);
        end
    endtask

    task automatic test_ordering();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0100; axi_resp.ar_ready = 1'b1;
        step();
        mem_we = 1'b1; mem_addr = 32'h0000_0200; axi_resp.ar_ready = 1'b0;
        axi_resp.aw_ready = 1'b1; axi_resp.w_ready = 1'b1;
        settle();
        n_checks++;
        if (mem_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL order_wr_gnt: got %b want 1", mem_gnt);
        end
        step();
        mem_req = 1'b0; axi_resp.aw_ready = 1'b0; axi_resp.w_ready = 1'b0;
        axi_resp.b_valid = 1'b1; axi_resp.b.resp = RespOkay;
        settle();
        n_checks++;
        if (axi_req.b_ready !== 1'b0 || mem_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL order_b_stall: b_ready=%b rvalid=%b want 0 0", axi_req.b_ready,
                     mem_rvalid);
        end
        step();
        axi_resp.r_valid = 1'b1; axi_resp.r.data = data_a;
        settle();
        n_checks++;
        if (axi_req.r_ready !== 1'b1 || axi_req.b_ready !== 1'b0 || mem_rvalid !== 1'b1 ||
            mem_rdata !== data_a) begin
            n_fail++;
            $display("FAIL order_first_r: r_ready=%b b_ready=%b rvalid=%b want 1 0 1",
                     axi_req.r_ready, axi_req.b_ready, mem_rvalid);
        end
        step();
        axi_resp.r_valid = 1'b0;
        settle();
        n_checks++;
        if (axi_req.b_ready !== 1'b1 || mem_rvalid !== 1'b1 || mem_rdata !== '0) begin
            n_fail++;
            $display("FAIL order_then_b: b_ready=%b rvalid=%b want 1 1", axi_req.b_ready,
                     mem_rvalid);
        end
        step();
        axi_resp.b_valid = 1'b0;
        settle();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL order_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_1000; axi_resp.ar_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_checks++;
            if (mem_gnt !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_gnt%0d: got %b want 1", i, mem_gnt);
            end
            step();
        end
        settle();
        n_checks++;
        if (mem_gnt !== 1'b0 || axi_req.ar_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full: gnt=%b ar_valid=%b want 0 0", mem_gnt, axi_req.ar_valid);
        end
        step();
        axi_resp.r_valid = 1'b1; axi_resp.r.data = data_b;
        settle();
        n_checks++;
        if (mem_gnt !== 1'b0 || mem_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_pop_no_gnt: gnt=%b rvalid=%b want 0 1", mem_gnt, mem_rvalid);
        end
        step();
        axi_resp.r_valid = 1'b0;
        settle();
        n_checks++;
        if (mem_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_fifth_gnt: got %b want 1", mem_gnt);
        end
        step();
        mem_req = 1'b0; axi_resp.ar_ready = 1'b0; axi_resp.r_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_checks++;
            if (mem_rvalid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_drain%0d: rvalid=%b want 1", i, mem_rvalid);
            end
            step();
        end
        axi_resp.r_valid = 1'b0;
        settle();
        n_checks++;
        if (busy !== 1'b0 || axi_req.r_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: busy=%b r_ready=%b want 0 0", busy, axi_req.r_ready);
        end
    endtask

    task automatic test_reset_mid();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_2000; axi_resp.ar_ready = 1'b1;
        step(); step();
        axi_resp.ar_ready = 1'b0; mem_we = 1'b1; axi_resp.aw_ready = 1'b1;
        step();
        axi_resp.aw_ready = 1'b0;
        settle();
        n_checks++;
        if (axi_req.aw_valid !== 1'b0 || axi_req.w_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_setup: aw_valid=%b w_valid=%b busy=%b want 0 1 1",
                     axi_req.aw_valid, axi_req.w_valid, busy);
        end
        rst = 1'b1; mem_req = 1'b0;
        step();
        rst = 1'b0;
        settle();
        n_checks++;
        if ({axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid, axi_req.r_ready,
             axi_req.b_ready, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got %b want 000000", {axi_req.ar_valid,
                     axi_req.aw_valid, axi_req.w_valid, axi_req.r_ready, axi_req.b_ready, busy});
        end
        mem_req = 1'b1; mem_we = 1'b1; axi_resp.aw_ready = 1'b1; axi_resp.w_ready = 1'b1;
        settle();
        n_checks++;
        if (axi_req.aw_valid !== 1'b1 || mem_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_fresh: aw_valid=%b gnt=%b want 1 1", axi_req.aw_valid, mem_gnt);
        end
        step();
        mem_req = 1'b0; axi_resp.aw_ready = 1'b0; axi_resp.w_ready = 1'b0;
        axi_resp.b_valid = 1'b1;
        settle();
        n_checks++;
        if (axi_req.b_ready !== 1'b1 || mem_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_b: b_ready=%b rvalid=%b want 1 1", axi_req.b_ready, mem_rvalid);
        end
        step();
        axi_resp.b_valid = 1'b0;
    endtask

    task automatic test_err();
        logic exp_err;
`ifdef MEM2AXI_MASTER_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        mem_req = 1'b1; mem_we = 1'b1; axi_resp.aw_ready = 1'b1; axi_resp.w_ready = 1'b1;
        step();
        mem_we = 1'b0; axi_resp.aw_ready = 1'b0; axi_resp.w_ready = 1'b0;
        axi_resp.ar_ready = 1'b1;
        step();
        mem_req = 1'b0; axi_resp.ar_ready = 1'b0;
        axi_resp.b_valid = 1'b1; axi_resp.b.resp = RespDecerr;
        settle();
        n_checks++;
        if (mem_rvalid !== 1'b1 || mem_err !== exp_err) begin
            n_fail++;
            $display("FAIL err_b_decerr: rvalid=%b err=%b want 1 %b", mem_rvalid, mem_err, exp_err);
        end
        step();
        axi_resp.b_valid = 1'b0; axi_resp.b.resp = RespOkay;
        axi_resp.r_valid = 1'b1; axi_resp.r.resp = RespSlverr; axi_resp.r.data = data_a;
        settle();
        n_checks++;
        if (mem_rvalid !== 1'b1 || mem_err !== exp_err || mem_rdata !== data_a) begin
            n_fail++;
            $display("FAIL err_r_slverr: rvalid=%b err=%b want 1 %b", mem_rvalid, mem_err, exp_err);
        end
        step();
        axi_resp.r_valid = 1'b0; axi_resp.r.resp = RespOkay;
        settle();
        n_checks++;
        if (mem_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL err_idle: err=%b busy=%b want 0 0", mem_err, busy);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_ordering();
        test_back_to_back();
        test_reset_mid();
        test_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
